// File: rtl/query_page_reader.sv
// query_page_reader: pulls page-finish commands and data beats from two
// FIFOs and streams each page downstream as a valid/ready beat sequence.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   cmd_fifo_empty/rd_en/dout   command FIFO (dout valid the cycle after
//                               rd_en; [31:0] dest_addr, [47:32] beat_cnt)
//   data_fifo_empty/rd_en/dout  data FIFO (dout valid the cycle after rd_en)
//   out_valid/ready/data/last/addr  downstream beat stream
//   busy         high in every state except IDLE
//   page_done    one-cycle pulse when a page completes
//   pages_done   completed-page counter (wraps)
//   pad_beats    stripped pad-beat counter (saturating)
//   err_zero_len sticky flag: a command arrived with beat_cnt = 0
//
// Build option: define QPR_PAD_STRIP_EN to drop beats whose low word equals
// PAD_WORD instead of forwarding them; otherwise pad_beats stays 0.

`timescale 1ns/1ps

module query_page_reader #(
    parameter logic [31:0] PAD_WORD = 32'h454E4444,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_fifo_empty,
    output logic             cmd_fifo_rd_en,
    input  logic [127:0]     cmd_fifo_dout,
    input  logic             data_fifo_empty,
    output logic             data_fifo_rd_en,
    input  logic [255:0]     data_fifo_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [255:0]     out_data,
    output logic             out_last,
    output logic [31:0]      out_addr,
    output logic             busy,
    output logic             page_done,
    output logic [CNT_W-1:0] pages_done,
    output logic [15:0]      pad_beats,
    output logic             err_zero_len
);

`ifdef QPR_PAD_STRIP_EN
    localparam bit StripPad = 1'b1;
`else
    localparam bit StripPad = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        CMD_REQ,
        CMD_CAP,
        DATA_REQ,
        DATA_CAP,
        DATA_OUT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [255:0]       data_q, data_d;
    logic [31:0]        addr_q, addr_d;
    logic [15:0]        rem_q, rem_d;
    logic [CNT_W-1:0]   pages_q, pages_d;
    logic [15:0]        pad_q, pad_d;
    logic               err_q, err_d;

    logic [15:0]        cmd_cnt;
    logic               is_pad;

    assign cmd_cnt = cmd_fifo_dout[47:32];
    assign is_pad  = (data_fifo_dout[31:0] == PAD_WORD);

    // Command word bits above beat_cnt carry nothing for this block.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_fifo_dout[127:48];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            pages_q <= '0;
            pad_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            pages_q <= pages_d;
            pad_q   <= pad_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        data_d          = data_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        pages_d         = pages_q;
        pad_d           = pad_q;
        err_d           = err_q;
        cmd_fifo_rd_en  = 1'b0;
        data_fifo_rd_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!cmd_fifo_empty) begin
                    state_d = CMD_REQ;
                end
            end

            // Gated on empty as well so a strobe can never hit an empty FIFO.
            CMD_REQ: begin
                if (!cmd_fifo_empty) begin
                    cmd_fifo_rd_en = 1'b1;
                    state_d        = CMD_CAP;
                end
            end

            CMD_CAP: begin
                addr_d = cmd_fifo_dout[31:0];
                rem_d  = cmd_cnt;
                if (cmd_cnt == 16'd0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DATA_REQ;
                end
            end

            DATA_REQ: begin
                if (!data_fifo_empty) begin
                    data_fifo_rd_en = 1'b1;
                    state_d         = DATA_CAP;
                end
            end

            // remaining is non-zero here, so the decrement cannot wrap.
            DATA_CAP: begin
                rem_d = rem_q - 16'd1;
                if (StripPad && is_pad) begin
                    if (pad_q != 16'hFFFF) begin
                        pad_d = pad_q + 16'd1;
                    end
                    state_d = (rem_q == 16'd1) ? DONE : DATA_REQ;
                end else begin
                    data_d  = data_fifo_dout;
                    state_d = DATA_OUT;
                end
            end

            DATA_OUT: begin
                if (out_ready) begin
                    state_d = (rem_q != 16'd0) ? DATA_REQ : DONE;
                end
            end

            DONE: begin
                pages_d = pages_q + CNT_W'(1);
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid    = (state_q == DATA_OUT);
    assign out_last     = (state_q == DATA_OUT) && (rem_q == 16'd0);
    assign out_data     = data_q;
    assign out_addr     = addr_q;
    assign busy         = (state_q != IDLE);
    assign page_done    = (state_q == DONE);
    assign pages_done   = pages_q;
    assign pad_beats    = pad_q;
    assign err_zero_len = err_q;

endmodule

// File: tb/tb_query_page_reader.sv
// tb_query_page_reader: randomized and directed stimulus for
// query_page_reader, checked against a page-level beat model.

`timescale 1ns/1ps

module tb_query_page_reader;

    localparam logic [31:0] PAD = 32'h454E4444;
`ifdef QPR_PAD_STRIP_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_empty = 1'b1;
    logic         cmd_rd;
    logic [127:0] cmd_dout = '0;
    logic         data_empty = 1'b1;
    logic         data_rd;
    logic [255:0] data_dout = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] out_data;
    logic         out_last;
    logic [31:0]  out_addr;
    logic         busy;
    logic         page_done;
    logic [31:0]  pages_done;
    logic [15:0]  pad_beats;
    logic         err_zero_len;

    always #5 clk = ~clk;

    query_page_reader #(.PAD_WORD(PAD), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_fifo_empty  (cmd_empty),
        .cmd_fifo_rd_en  (cmd_rd),
        .cmd_fifo_dout   (cmd_dout),
        .data_fifo_empty (data_empty),
        .data_fifo_rd_en (data_rd),
        .data_fifo_dout  (data_dout),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .out_addr        (out_addr),
        .busy            (busy),
        .page_done       (page_done),
        .pages_done      (pages_done),
        .pad_beats       (pad_beats),
        .err_zero_len    (err_zero_len)
    );

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  a;
        logic         l;
    } beat_t;

    beat_t        expq[$];
    beat_t        logq[$];
    logic [127:0] cmdq[$];
    logic [255:0] dataq[$];
    logic [255:0] holdq[$];

    int vecs = 0;
    int errs = 0;
    int exp_pages = 0;
    int seen_pages = 0;
    int exp_pad = 0;
    int drd_total = 0;
    bit exp_err = 1'b0;
    bit rmode = 1'b0;
    bit rforce = 1'b1;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // FIFO models: dout updates just after the edge that sampled rd_en.
    always begin
        bit crd, drd;
        @(negedge clk);
        crd = cmd_rd;
        drd = data_rd;
        @(posedge clk);
        #1;
        if (crd && cmdq.size() > 0) cmd_dout = cmdq.pop_front();
        if (drd && dataq.size() > 0) data_dout = dataq.pop_front();
        #1;
        cmd_empty  = (cmdq.size() == 0);
        data_empty = (dataq.size() == 0);
    end

    always begin
        @(posedge clk);
        #1;
        out_ready = rmode ? 1'($urandom_range(0, 1)) : rforce;
    end

    // Per-cycle compare against the model.
    bit    pv = 1'b0;
    beat_t pb;
    always @(negedge clk) begin
        if (!rst) begin
            pv = 1'b0;
        end else begin
            beat_t e;
            chk("rd_exclusive", {255'd0, cmd_rd & data_rd}, '0);
            if (cmd_rd) chk("cmd_rd_on_empty", {255'd0, cmd_empty}, '0);
            if (data_rd) chk("data_rd_on_empty", {255'd0, data_empty}, '0);
            if (data_rd) drd_total++;
            if (pv) begin
                chk("hold_valid", {255'd0, out_valid}, 256'd1);
                chk("hold_data", out_data, pb.d);
                chk("hold_addr", {224'd0, out_addr}, {224'd0, pb.a});
                chk("hold_last", {255'd0, out_last}, {255'd0, pb.l});
            end
            chk("pages_done", {224'd0, pages_done}, 256'(seen_pages));
            if (out_valid && out_ready) begin
                vecs++;
                if (expq.size() == 0) begin
                    errs++;
                    $display("FAIL beat_unexpected actual=%0h required=none",
                             out_data);
                end else begin
                    e = expq.pop_front();
                    chk("beat_data", out_data, e.d);
                    chk("beat_addr", {224'd0, out_addr}, {224'd0, e.a});
                    chk("beat_last", {255'd0, out_last}, {255'd0, e.l});
                end
                logq.push_back({out_data, out_addr, out_last});
            end
            if (page_done) seen_pages++;
            pv = out_valid && !out_ready;
            pb = {out_data, out_addr, out_last};
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [255:0] gen_beat(input bit pad);
        logic [255:0] b;
        logic [31:0]  w;
        for (int k = 1; k < 8; k++) b[k*32 +: 32] = $urandom;
        w = $urandom;
        if (w == PAD) w = w ^ 32'h1;
        b[31:0] = pad ? PAD : w;
        return b;
    endfunction

    // Model: a page yields its non-pad beats (all beats when stripping is
    // off); only the page's final beat carries last.
    task automatic add_page(input logic [31:0] a, input int cnt,
                            input int padidx, input int npush);
        logic [255:0] b;
        cmdq.push_back({80'd0, 16'(cnt), a});
        if (cnt == 0) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < cnt; i++) begin
                b = gen_beat(i == padidx);
                if (PadEn && b[31:0] == PAD) begin
                    if (exp_pad < 65535) exp_pad++;
                end else begin
                    expq.push_back({b, a, 1'(i == cnt - 1)});
                end
                if (i < npush) dataq.push_back(b);
                else holdq.push_back(b);
            end
            exp_pages++;
        end
    endtask

    task automatic release_hold();
        while (holdq.size() > 0) dataq.push_back(holdq.pop_front());
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (!(cmdq.size() == 0 && expq.size() == 0 && !busy &&
                 cmd_empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (n >= budget) begin
            errs++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int cnt, input int budget);
        int n = 0;
        @(negedge clk);
        while (logq.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (n >= budget) begin
            errs++;
            $display("FAIL log_timeout actual=%0d required=%0d",
                     logq.size(), cnt);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, {255'd0, busy}, '0);
        chk({nm, "_valid"}, {255'd0, out_valid}, '0);
        chk({nm, "_last"}, {255'd0, out_last}, '0);
        chk({nm, "_pdone"}, {255'd0, page_done}, '0);
        chk({nm, "_rd"}, {254'd0, cmd_rd, data_rd}, '0);
        chk({nm, "_data"}, out_data, '0);
        chk({nm, "_addr"}, {224'd0, out_addr}, '0);
        chk({nm, "_pages"}, {224'd0, pages_done}, '0);
        chk({nm, "_pad"}, {240'd0, pad_beats}, '0);
        chk({nm, "_err"}, {255'd0, err_zero_len}, '0);
    endtask

    initial begin
        int d0;
        int p0;
        logic [255:0] b1;

        step(3);
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        step(2);

        // Basic three-beat page.
        logq.delete();
        add_page(32'h1000, 3, -1, 3);
        wait_idle(200);
        chk("t1_count", 256'(logq.size()), 256'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_addr", {224'd0, logq[i].a}, {224'd0, 32'h1000});
            chk("t1_last", {255'd0, logq[i].l}, 256'(i == 2));
        end
        chk("t1_pages", {224'd0, pages_done}, 256'd1);
        chk("t1_err", {255'd0, err_zero_len}, '0);

        // Backpressure on beat 1.
        logq.delete();
        rforce = 1'b0;
        add_page(32'h2000, 2, -1, 2);
        b1 = expq[0].d;
        wait_log(0, 1);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (5) begin
            chk("t2_valid", {255'd0, out_valid}, 256'd1);
            chk("t2_data", out_data, b1);
            chk("t2_drd", {255'd0, data_rd}, '0);
            @(negedge clk);
        end
        rforce = 1'b1;
        wait_idle(200);
        chk("t2_count", 256'(logq.size()), 256'd2);
        chk("t2_last0", {255'd0, logq[0].l}, '0);
        chk("t2_last1", {255'd0, logq[1].l}, 256'd1);
        chk("t2_pages", {224'd0, pages_done}, 256'd2);

        // Zero-length command, then a normal one.
        d0 = drd_total;
        add_page(32'h3000, 0, -1, 0);
        wait_idle(100);
        chk("t3_err", {255'd0, err_zero_len}, 256'd1);
        chk("t3_pages", {224'd0, pages_done}, 256'd2);
        chk("t3_drd", 256'(drd_total), 256'(d0));
        logq.delete();
        add_page(32'h3100, 2, -1, 2);
        wait_idle(200);
        chk("t3b_count", 256'(logq.size()), 256'd2);
        chk("t3b_pages", {224'd0, pages_done}, 256'd3);

        // Data FIFO runs dry after beat 2.
        logq.delete();
        add_page(32'h4000, 4, -1, 2);
        wait_log(2, 200);
        @(negedge clk);
        repeat (10) begin
            chk("t4_drd", {255'd0, data_rd}, '0);
            chk("t4_busy", {255'd0, busy}, 256'd1);
            chk("t4_valid", {255'd0, out_valid}, '0);
            @(negedge clk);
        end
        release_hold();
        wait_idle(200);
        chk("t4_count", 256'(logq.size()), 256'd4);
        chk("t4_pages", {224'd0, pages_done}, 256'd4);

        // Pad word in the final beat.
        logq.delete();
        p0 = int'(pad_beats);
        add_page(32'h5000, 3, 2, 3);
        wait_idle(200);
`ifdef QPR_PAD_STRIP_EN
        chk("t5_count", 256'(logq.size()), 256'd2);
        chk("t5_last1", {255'd0, logq[1].l}, '0);
        chk("t5_pad", {240'd0, pad_beats}, 256'(p0 + 1));
`else
        chk("t5_count", 256'(logq.size()), 256'd3);
        chk("t5_last2", {255'd0, logq[2].l}, 256'd1);
        chk("t5_pad", {240'd0, pad_beats}, 256'd0);
`endif
        chk("t5_pages", {224'd0, pages_done}, 256'd5);

        // Random pages.
        rmode = 1'b1;
        for (int p = 0; p < 30; p++) begin
            int cnt;
            int pidx;
            cnt  = $urandom_range(1, 6);
            pidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cnt - 1)
                                                : -1;
            add_page($urandom, cnt, pidx, $urandom_range(0, cnt));
            step($urandom_range(0, 8));
            release_hold();
            wait_idle(500);
        end
        chk("rnd_pages", {224'd0, pages_done}, 256'(exp_pages));
        chk("rnd_pad", {240'd0, pad_beats}, 256'(exp_pad));
        chk("rnd_err", {255'd0, err_zero_len}, {255'd0, exp_err});
        chk("rnd_left", 256'(expq.size()), '0);

        // Reset in the middle of a page.
        rmode = 1'b0;
        rforce = 1'b1;
        logq.delete();
        add_page(32'h6000, 3, -1, 3);
        wait_log(1, 200);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        step(3);
        chk_zero("midrst_hold");
        expq.delete();
        cmdq.delete();
        dataq.delete();
        holdq.delete();
        seen_pages = 0;
        exp_pages  = 0;
        exp_pad    = 0;
        exp_err    = 1'b0;
        step(1);
        @(negedge clk);
        rst = 1'b1;
        step(2);
        logq.delete();
        add_page(32'h7000, 2, -1, 2);
        wait_idle(200);
        chk("t6_count", 256'(logq.size()), 256'd2);
        chk("t6_addr", {224'd0, logq[0].a}, {224'd0, 32'h7000});
        chk("t6_pages", {224'd0, pages_done}, 256'd1);
        chk("t6_err", {255'd0, err_zero_len}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
